// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file datapath blocks:
// ALU opcodes, initiator FSM states and default address/key constants.
package regfile_pkg;

  localparam int REG_AW = 10;
  localparam int REG_DW = 32;

  localparam logic [REG_AW-1:0] PARK_ADDR_DEF = 10'h3FF;
  localparam logic [15:0]       EXP_KEY_DEF   = 16'h0032;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_SRL  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EX   = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by the datapath blocks.
// Arithmetic wraps; shifts use only the low log2(DW) bits of b.
module alu_core
  import regfile_pkg::*;
#(
  parameter int DW = REG_DW
) (
  input  alu_op_t       i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_y
);

  localparam int SHW = $clog2(DW);

  logic [SHW-1:0] w_shamt;
  logic           w_unused_b;

  assign w_shamt    = i_b[SHW-1:0];
  // Upper bits of b do not take part in shift amounts.
  assign w_unused_b = ^i_b[DW-1:SHW];

  // Fully decoded opcode; every 3-bit value has a defined result.
  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SLL:  o_y = i_a << w_shamt;
      ALU_SRL:  o_y = i_a >> w_shamt;
      ALU_PASS: o_y = i_a;
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_alu_initiator.sv
// Drives the read ports and the always-writing ALU port of the register
// file. One instruction per handshake: RD issues addresses, EX computes
// on the registered read data, WB drives the write for one cycle. In
// every other cycle the ALU port is parked on the scratch address.
module regfile_alu_initiator
  import regfile_pkg::*;
#(
  parameter int              AW        = REG_AW,
  parameter int              DW        = REG_DW,
  parameter logic [AW-1:0]   PARK_ADDR = AW'(PARK_ADDR_DEF),
  parameter logic [15:0]     EXP_KEY   = EXP_KEY_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_src1,
  input  logic [AW-1:0] instr_src2,
  input  logic [AW-1:0] instr_dst,
  input  logic [15:0]   key_access,
  output logic [AW-1:0] reg1,
  output logic [AW-1:0] reg2,
  input  logic [DW-1:0] read_reg1,
  input  logic [DW-1:0] read_reg2,
  output logic [AW-1:0] address_alu,
  output logic [DW-1:0] write_data_alu,
  output logic [DW-1:0] result,
  output logic          done,
  output logic          err_key,
  output logic          err_addr,
  output logic          busy
);

  state_t        r_state, w_state_next;
  logic          r_instr_ready, w_ready_next;
  logic [AW-1:0] r_reg1, r_reg2;
  logic [AW-1:0] r_address_alu, w_addr_next;
  logic [DW-1:0] r_write_data_alu, w_wdata_next;
  logic [DW-1:0] r_result;
  logic          r_done, w_done_next;
  logic          r_err_key, w_err_key_next;
  logic          r_err_addr, w_err_addr_next;
  logic          r_busy, w_busy_next;
  alu_op_t       r_op;
  logic [AW-1:0] r_dst;
  logic          w_accept, w_capture, w_start;
  logic [DW-1:0] w_alu_y;

  assign w_accept = instr_valid && r_instr_ready;

  alu_core #(.DW(DW)) u_alu (
    .i_op (r_op),
    .i_a  (read_reg1),
    .i_b  (read_reg2),
    .o_y  (w_alu_y)
  );

  // Next state and next registered outputs; the ALU port defaults to park.
  always_comb begin
    w_state_next    = r_state;
    w_ready_next    = 1'b0;
    w_addr_next     = PARK_ADDR;
    w_wdata_next    = '0;
    w_done_next     = 1'b0;
    w_err_key_next  = 1'b0;
    w_err_addr_next = 1'b0;
    w_capture       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready_next = 1'b1;
        if (w_accept) begin
          w_capture = 1'b1;
          // Key failure takes priority over a parked destination.
          if (key_access != EXP_KEY) begin
            w_err_key_next = 1'b1;
          end else if (instr_dst == PARK_ADDR) begin
            w_err_addr_next = 1'b1;
          end else begin
            w_state_next = ST_RD;
            w_ready_next = 1'b0;
          end
        end
      end
      ST_RD: w_state_next = ST_EX;
      ST_EX: begin
        // Result is registered together with the WB write outputs.
        w_state_next = ST_WB;
        w_addr_next  = r_dst;
        w_wdata_next = w_alu_y;
        w_done_next  = 1'b1;
      end
      ST_WB: begin
        w_state_next = ST_IDLE;
        w_ready_next = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_busy_next = (w_state_next != ST_IDLE);
    w_start     = (r_state == ST_IDLE) && (w_state_next == ST_RD);
  end

  // State and control/write-port output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_instr_ready    <= 1'b1;
      r_address_alu    <= PARK_ADDR;
      r_write_data_alu <= '0;
      r_done           <= 1'b0;
      r_err_key        <= 1'b0;
      r_err_addr       <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_instr_ready    <= w_ready_next;
      r_address_alu    <= w_addr_next;
      r_write_data_alu <= w_wdata_next;
      r_done           <= w_done_next;
      r_err_key        <= w_err_key_next;
      r_err_addr       <= w_err_addr_next;
      r_busy           <= w_busy_next;
    end
  end

  // Instruction capture, read addresses (only change entering RD) and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= ALU_ADD;
      r_dst    <= '0;
      r_reg1   <= '0;
      r_reg2   <= '0;
      r_result <= '0;
    end else begin
      if (w_capture) begin
        r_op  <= alu_op_t'(instr_op);
        r_dst <= instr_dst;
      end
      if (w_start) begin
        r_reg1 <= instr_src1;
        r_reg2 <= instr_src2;
      end
      if (r_state == ST_EX) begin
        r_result <= w_alu_y;
      end
    end
  end

  assign instr_ready    = r_instr_ready;
  assign reg1           = r_reg1;
  assign reg2           = r_reg2;
  assign address_alu    = r_address_alu;
  assign write_data_alu = r_write_data_alu;
  assign result         = r_result;
  assign done           = r_done;
  assign err_key        = r_err_key;
  assign err_addr       = r_err_addr;
  assign busy           = r_busy;

endmodule

// File: doc/regfile_alu_initiator.md
Name: regfile_alu_initiator

Overview:
- Initiator that drives the read and ALU-write side of the 1024x32 register file.
- Accepts one ALU instruction per valid/ready handshake: op, two source addresses, one destination address.
- Issues both reads, waits one cycle for registered read data, computes the result, then writes it back through the ALU write port.
- The register file has no write enable and writes its ALU port on every clock edge, so this block parks that port on a reserved scratch address whenever it is not writing.

Parameters:
- AW, 10, register-file address width
- DW, 32, data width
- PARK_ADDR, 10'h3FF, reserved scratch location that receives all idle ALU-port writes
- EXP_KEY, 16'h0032, required value on key_access for an instruction to execute

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 PASS(src1)
- instr_src1  in  AW  first source address
- instr_src2  in  AW  second source address
- instr_dst  in  AW  destination address
- key_access  in  16  access key from the register file
- reg1  out  AW  read address 1 to the register file
- reg2  out  AW  read address 2 to the register file
- read_reg1  in  DW  registered read data 1
- read_reg2  in  DW  registered read data 2
- address_alu  out  AW  ALU write address
- write_data_alu  out  DW  ALU write data
- result  out  DW  last computed result, held until overwritten
- done  out  1  one-cycle pulse in the cycle the write is driven
- err_key  out  1  one-cycle pulse when an instruction is dropped for a key mismatch
- err_addr  out  1  one-cycle pulse when an instruction is dropped because dst == PARK_ADDR
- busy  out  1  high when the state is not IDLE

Behaviour:
- All outputs are registered.
- Reset values: instr_ready=1, reg1=0, reg2=0, address_alu=PARK_ADDR, write_data_alu=0, result=0, done=0, err_key=0, err_addr=0, busy=0, state=IDLE.
- FSM states: IDLE -> RD -> EX -> WB -> IDLE. Throughput is one instruction per 4 cycles. Latency from accept edge to the write edge is 3 cycles.
- IDLE:
  - instr_ready=1.
  - Handshake occurs when instr_valid && instr_ready at a posedge.
  - On handshake, capture op, src1, src2, dst.
  - If key_access != EXP_KEY: pulse err_key next cycle, stay in IDLE, no write.
  - Else if dst == PARK_ADDR: pulse err_addr, stay in IDLE, no write.
  - Else go to RD.
  - If both errors apply, only err_key pulses.
- RD:
  - instr_ready=0; reg1=src1, reg2=src2.
  - The register file samples the addresses at the end of this cycle.
- EX:
  - read_reg1/read_reg2 are valid in this cycle.
  - Compute the result and register it into result at the end of EX.
  - ADD and SUB wrap modulo 2^32; no carry or overflow is reported.
  - SLL and SRL shift src1 data by src2 data[4:0]; SRL is logical.
- WB:
  - address_alu=dst, write_data_alu=result, done=1 for this single cycle.
  - Next state is IDLE, where address_alu returns to PARK_ADDR and write_data_alu to 0.
- Outside WB, address_alu=PARK_ADDR always.
- Read-after-write hazard: a write in WB lands at the end of WB. The next instruction's RD is at least 2 cycles later, so back-to-back dependent instructions read the new value without forwarding.
- src1 == src2 and src == dst are legal.
- reg1 and reg2 hold their last value outside RD.
- Reset mid-operation: the next state is IDLE, no write occurs, and address_alu is PARK_ADDR in the cycle after the reset edge.
- Undefined instr_op values cannot occur (3-bit field is fully decoded).

Decomposition:
- Shared package regfile_pkg: opcode enum alu_op_t (8 codes), FSM state enum, PARK_ADDR and EXP_KEY defaults.
- One sub-module alu_core: purely combinational (op, a, b) -> y. It is instantiated once and also reused by other datapath blocks.

Test Plan:
- Preload mem[5]=32'd7, mem[6]=32'd9; instr ADD src1=5 src2=6 dst=10 -> done exactly 3 cycles after accept, mem[10]=32'd16, result=16.
- mem[1]=0, mem[2]=1; SUB dst=3 -> mem[3]=32'hFFFFFFFF (wrap). mem[4]=32'h80000000; SRL src1=4 src2=2 (data 1) -> 32'h40000000.
- ADD 5,6 -> dst 7, then immediately ADD 7,7 -> dst 8 with instr_valid held high -> mem[8]=32'd32; instr_ready low for 3 cycles between accepts.
- key_access=16'h0031 during handshake -> err_key pulses once, no done, mem[dst] unchanged, address_alu stays 10'h3FF.
- dst=10'h3FF with a valid key -> err_addr pulse, no write. Assert rst during EX -> no done, address_alu=10'h3FF the next cycle, mem[dst] unchanged, instr_ready=1.
